// File: rtl/ram_4kx4.sv
// ram_4kx4: single-port synchronous RAM, 2^ADDR_WIDTH words by DATA_WIDTH bits.
// This is the main data store of the 4-bit CPU datapath.
// Writes and reads both happen on the rising clock edge.
// Read data is registered. It holds its value between reads.
// When a read and a write hit the same edge, the read returns the data being
// written (write-first).
// Reset clears only the output register and blocks any access in that cycle.
// The storage array keeps its contents through reset.
module ram_4kx4 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wen_i,
  input  logic                  ren_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int Depth = 1 << ADDR_WIDTH;

  // Every word starts at zero, both in simulation and from the FPGA bitstream.
  logic [DATA_WIDTH-1:0] mem [0:Depth-1] = '{default: '0};

  // The output register also starts at zero, so the output is defined before
  // the first read or reset.
  logic [DATA_WIDTH-1:0] dout_q = '0;

  // Storage array write port. A write in the same cycle as reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wen_i) begin
      mem[addr_i] <= din_i;
    end
  end

  // Registered read port. Reset clears it and ren_i low holds it.
  // During a collision it takes din_i directly, so the output shows the new word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (ren_i) begin
      if (wen_i) begin
        dout_q <= din_i;
      end else begin
        dout_q <= mem[addr_i];
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: tb/tb_ram_4kx4.sv
// tb_ram_4kx4: self-checking bench for ram_4kx4.
// Each call to applyStimulus drives one cycle of inputs on the falling edge.
// It pushes the required output value onto a scoreboard queue.
// After the next rising edge it pops that value and compares it to the output.
module tb_ram_4kx4;

  localparam int AW = 12;
  localparam int DW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wen_i = 1'b0;
  logic          ren_i = 1'b0;
  logic [DW-1:0] din_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] dout_o;

  int assertCount = 0;
  int failCount = 0;

  logic [DW-1:0] modelMem [0:(1<<AW)-1];
  logic [DW-1:0] modelDout;
  logic [DW-1:0] expQ [$];
  string         tagQ [$];

  ram_4kx4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wen_i (wen_i),
    .ren_i (ren_i),
    .din_i (din_i),
    .addr_i(addr_i),
    .dout_o(dout_o)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: dout_o=0x%h required 0x%h", tag, got, exp);
    end
  endtask

  // Drives one cycle and queues the required output.
  // Then it waits past the rising edge and checks the result.
  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input string tag);
    logic [DW-1:0] exp;
    rst_i  = r;
    wen_i  = w;
    ren_i  = rd;
    addr_i = a;
    din_i  = d;
    exp = modelDout;
    if (r) exp = '0;
    else if (rd) exp = w ? d : modelMem[a];
    if (!r && w) modelMem[a] = d;
    modelDout = exp;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput(tagQ.pop_front(), dout_o, expQ.pop_front());
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) modelMem[i] = '0;
    modelDout = '0;

    @(negedge clk_i);
    checkOutput("init_dout", dout_o, 4'h0);

    // Test 1: write to address 0, then read it back.
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 4'b0011, "t1_write_a");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 4'b0011, "t1_write_b");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 4'b0011, "t1_read");
    checkOutput("t1_literal", dout_o, 4'b0011);

    // Test 2: disabled write, then write, read, hold, and re-read.
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h001, 4'b0101, "t2_idle_a");
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h001, 4'b0101, "t2_idle_b");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h001, 4'b0101, "t2_write_a");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h001, 4'b0101, "t2_write_b");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h001, 4'b0101, "t2_read");
    checkOutput("t2_read_literal", dout_o, 4'b0101);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 4'b0101, "t2_hold");
    checkOutput("t2_hold_literal", dout_o, 4'b0101);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 4'b0101, "t2_reread");
    checkOutput("t2_reread_literal", dout_o, 4'b0011);

    // Test 3: boundary addresses.
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 4'hA, "t3_wr_000");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'hFFF, 4'h5, "t3_wr_fff");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h7FF, 4'hF, "t3_wr_7ff");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 4'h0, "t3_rd_000");
    checkOutput("t3_lit_000", dout_o, 4'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFF, 4'h0, "t3_rd_fff");
    checkOutput("t3_lit_fff", dout_o, 4'h5);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h7FF, 4'h0, "t3_rd_7ff");
    checkOutput("t3_lit_7ff", dout_o, 4'hF);

    // Test 4: write-first collision.
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 4'h3, "t4_preload");
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h010, 4'hC, "t4_collide");
    checkOutput("t4_collide_lit", dout_o, 4'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 4'h0, "t4_idle");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h010, 4'h0, "t4_reread");
    checkOutput("t4_reread_lit", dout_o, 4'hC);

    // Test 5: reset blocks the write, clears dout, and keeps memory contents.
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFF, 4'h0, "t5_setup");
    checkOutput("t5_setup_lit", dout_o, 4'h5);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h020, 4'h9, "t5_reset");
    checkOutput("t5_reset_lit", dout_o, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h020, 4'h0, "t5_rd_020");
    checkOutput("t5_rd_020_lit", dout_o, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFF, 4'h0, "t5_rd_fff");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 4'h0, "t5_rd_000");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h7FF, 4'h0, "t5_rd_7ff");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h001, 4'h0, "t5_rd_001");
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h010, 4'h0, "t5_rd_010");
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h030, 4'h7, "t5_pre_rst_rd");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h030, 4'h0, "t5_reset_rd");

    // Test 6: random sweep.
    // Addresses come from a small hot set, so writes and reads often hit the
    // same word, or from the full range. Reset is asserted occasionally.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      logic r;
      if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 15)) << 8;
      else a = AW'($urandom_range(0, (1 << AW) - 1));
      r = ($urandom_range(0, 39) == 0);
      applyStimulus(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                    DW'($urandom_range(0, 15)), "t6_random");
    end

    if (expQ.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0",
               expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
